// File: rtl/axi_lite_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_rd_arbiter
// Description : 2:1 AXI-lite read arbiter (IFU = m0, LSU = m1) in front of a
//               read-only SRAM slave. One outstanding transaction, with a
//               slave-response timeout watchdog that answers SLVERR.
//               Define ARB_ROUND_ROBIN_EN for round-robin arbitration;
//               otherwise fixed priority with m1 above m0.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_rd_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 64,
    parameter int TMO_CYC = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    // master 0 (IFU)
    input  logic [AW-1:0] m0_araddr,
    input  logic          m0_arvalid,
    output logic          m0_arready,
    output logic [DW-1:0] m0_rdata,
    output logic [1:0]    m0_rresp,
    output logic          m0_rvalid,
    input  logic          m0_rready,
    // master 1 (LSU)
    input  logic [AW-1:0] m1_araddr,
    input  logic          m1_arvalid,
    output logic          m1_arready,
    output logic [DW-1:0] m1_rdata,
    output logic [1:0]    m1_rresp,
    output logic          m1_rvalid,
    input  logic          m1_rready,
    // slave (SRAM)
    output logic [AW-1:0] s_araddr,
    output logic          s_arvalid,
    input  logic          s_arready,
    input  logic [DW-1:0] s_rdata,
    input  logic [1:0]    s_rresp,
    input  logic          s_rvalid,
    output logic          s_rready
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_ADDR = 2'd1;
    localparam logic [1:0] c_DATA = 2'd2;
    localparam logic [1:0] c_TERR = 2'd3;

    localparam logic [7:0] c_TMO        = 8'(TMO_CYC);
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic          r_grant;
    logic [AW-1:0] r_araddr;
    logic [7:0]    r_cnt;

    logic          w_any;
    logic          w_win;
    logic          w_sel_rready;
    logic [7:0]    w_cnt_inc;

    assign w_any        = m0_arvalid | m1_arvalid;
    assign w_sel_rready = r_grant ? m1_rready : m0_rready;
    assign w_cnt_inc    = r_cnt + 8'd1;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_grant;

    // On a tie the master that was not served last wins.
    assign w_win = (m0_arvalid && m1_arvalid) ? ~r_last_grant : m1_arvalid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (r_state == c_IDLE && w_any) begin
            r_last_grant <= w_win;
        end
    end
`else
    assign w_win = m1_arvalid;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant, address latch and watchdog counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant  <= 1'b0;
            r_araddr <= '0;
            r_cnt    <= 8'd0;
        end else begin
            if (r_state == c_IDLE && w_any) begin
                r_grant  <= w_win;
                r_araddr <= w_win ? m1_araddr : m0_araddr;
            end
            if (r_state == c_ADDR && s_arready) begin
                r_cnt <= 8'd0;
            end else if (r_state == c_DATA && !s_rvalid) begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: if (w_any) w_next = c_ADDR;
            c_ADDR: if (s_arready) w_next = c_DATA;
            c_DATA: begin
                if (s_rvalid && w_sel_rready) begin
                    w_next = c_IDLE;
                end else if (!s_rvalid && w_cnt_inc == c_TMO) begin
                    // The increment that reaches TMO_CYC lands us in TERR
                    w_next = c_TERR;
                end
            end
            c_TERR: if (w_sel_rready) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        m0_rresp   = 2'b00;
        m1_rresp   = 2'b00;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        case (r_state)
            c_IDLE: begin
                m0_arready = w_any & ~w_win;
                m1_arready = w_any &  w_win;
            end
            c_ADDR: s_arvalid = 1'b1;
            c_DATA: begin
                s_rready = w_sel_rready;
                if (s_rvalid) begin
                    if (r_grant) begin
                        m1_rvalid = 1'b1;
                        m1_rdata  = s_rdata;
                        m1_rresp  = s_rresp;
                    end else begin
                        m0_rvalid = 1'b1;
                        m0_rdata  = s_rdata;
                        m0_rresp  = s_rresp;
                    end
                end
            end
            c_TERR: begin
                // Slave is ignored here; a late s_rvalid must not leak through
                if (r_grant) begin
                    m1_rvalid = 1'b1;
                    m1_rresp  = c_RESP_SLVERR;
                end else begin
                    m0_rvalid = 1'b1;
                    m0_rresp  = c_RESP_SLVERR;
                end
            end
            default: ;
        endcase
    end

    assign s_araddr = r_araddr;

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_lite_rd_arbiter
// Description : Directed self-checking bench for axi_lite_rd_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_lite_rd_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] m0_araddr, m1_araddr, s_araddr;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [63:0] m0_rdata, m1_rdata, s_rdata;
    logic [1:0]  m0_rresp, m1_rresp, s_rresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;

    int n_asserts = 0;
    int n_fail    = 0;

    logic        fw;
    logic [31:0] addr_w, addr_l;

    axi_lite_rd_arbiter #(.AW(32), .DW(64), .TMO_CYC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        m0_araddr = '0; m0_arvalid = 1'b0; m0_rready = 1'b0;
        m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b0;
        s_arready = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rvalid = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        fw = 1'b0;
`else
        fw = 1'b1;
`endif
        tick; tick; tick;

        // Reset state
        chk("rst_m0_arready", m0_arready, 0);
        chk("rst_m1_arready", m1_arready, 0);
        chk("rst_s_arvalid",  s_arvalid, 0);
        chk("rst_s_araddr",   s_araddr, 0);
        chk("rst_s_rready",   s_rready, 0);
        chk("rst_m0_rvalid",  m0_rvalid, 0);
        chk("rst_m1_rvalid",  m1_rvalid, 0);
        chk("rst_m0_rdata",   m0_rdata, 0);
        rst_n = 1'b1;

        // 1: m0 only, minimum latency
        tick;
        m0_araddr = 32'h8000_0000; m0_arvalid = 1'b1; m0_rready = 1'b1; s_arready = 1'b1;
        settle;
        chk("t1_m0_arready", m0_arready, 1);
        chk("t1_m1_arready", m1_arready, 0);
        tick;
        m0_arvalid = 1'b0;
        settle;
        chk("t1_s_arvalid", s_arvalid, 1);
        chk("t1_s_araddr",  s_araddr, 32'h8000_0000);
        chk("t1_m0_rvalid_c1", m0_rvalid, 0);
        tick;
        s_rvalid = 1'b1; s_rdata = 64'h13; s_rresp = 2'b00;
        settle;
        chk("t1_m0_rvalid", m0_rvalid, 1);
        chk("t1_m0_rdata",  m0_rdata, 64'h13);
        chk("t1_m0_rresp",  m0_rresp, 0);
        chk("t1_m1_rvalid", m1_rvalid, 0);
        chk("t1_s_rready",  s_rready, 1);
        tick;
        s_rvalid = 1'b0;
        settle;
        chk("t1_done_m0_rvalid", m0_rvalid, 0);
        chk("t1_done_s_arvalid", s_arvalid, 0);

        // 2: simultaneous requests, fresh reset so round-robin starts from last_grant=1
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        addr_w = fw ? 32'h200 : 32'h100;
        addr_l = fw ? 32'h100 : 32'h200;
        m0_araddr = 32'h100; m1_araddr = 32'h200;
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; m0_rready = 1'b1; m1_rready = 1'b1;
        settle;
        chk("t2_m1_arready", m1_arready, fw);
        chk("t2_m0_arready", m0_arready, !fw);
        tick;
        if (fw) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
        settle;
        chk("t2_s_araddr_w", s_araddr, addr_w);
        chk("t2_loser_arready_addr", fw ? m0_arready : m1_arready, 0);
        tick;
        s_rvalid = 1'b1; s_rdata = 64'hA1;
        settle;
        chk("t2_win_rvalid", fw ? m1_rvalid : m0_rvalid, 1);
        chk("t2_win_rdata",  fw ? m1_rdata : m0_rdata, 64'hA1);
        chk("t2_lose_rvalid", fw ? m0_rvalid : m1_rvalid, 0);
        chk("t2_loser_arready_data", fw ? m0_arready : m1_arready, 0);
        tick;
        s_rvalid = 1'b0;
        settle;
        chk("t2_loser_arready_idle", fw ? m0_arready : m1_arready, 1);
        tick;
        if (fw) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
        settle;
        chk("t2_s_araddr_l", s_araddr, addr_l);
        tick;
        s_rvalid = 1'b1; s_rdata = 64'hB2;
        settle;
        chk("t2_lose_rvalid2", fw ? m0_rvalid : m1_rvalid, 1);
        chk("t2_lose_rdata2",  fw ? m0_rdata : m1_rdata, 64'hB2);
        chk("t2_win_rvalid2",  fw ? m1_rvalid : m0_rvalid, 0);
        tick;
        s_rvalid = 1'b0;
        settle;
        chk("t2_done_s_rready", s_rready, 0);

        // 3: slave stalls address phase for 5 cycles
        m0_araddr = 32'h300; m0_arvalid = 1'b1; s_arready = 1'b0;
        settle;
        tick;
        m0_arvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle;
            chk("t3_s_arvalid_hold", s_arvalid, 1);
            chk("t3_s_araddr_hold",  s_araddr, 32'h300);
            tick;
        end
        s_arready = 1'b1;
        settle;
        chk("t3_s_arvalid_6th", s_arvalid, 1);
        tick;
        settle;
        chk("t3_data_s_arvalid", s_arvalid, 0);
        chk("t3_data_s_rready",  s_rready, 1);
        chk("t3_data_m0_rvalid", m0_rvalid, 0);
        s_rvalid = 1'b1; s_rdata = 64'h33;
        settle;
        chk("t3_m0_rdata", m0_rdata, 64'h33);
        tick;
        s_rvalid = 1'b0;

        // 4: slave never answers, TMO_CYC=4
        m1_araddr = 32'h400; m1_arvalid = 1'b1; m1_rready = 1'b0;
        settle;
        tick;
        m1_arvalid = 1'b0;
        tick;
        for (int i = 0; i < 4; i++) begin
            settle;
            chk("t4_m1_rvalid_wait", m1_rvalid, 0);
            tick;
        end
        settle;
        chk("t4_terr_rvalid", m1_rvalid, 1);
        chk("t4_terr_rresp",  m1_rresp, 2'b10);
        chk("t4_terr_rdata",  m1_rdata, 0);
        chk("t4_terr_m0_rvalid", m0_rvalid, 0);
        s_rvalid = 1'b1; s_rdata = 64'hDEAD;
        settle;
        chk("t4_late_rdata",   m1_rdata, 0);
        chk("t4_late_s_rready", s_rready, 0);
        tick;
        m1_rready = 1'b1;
        settle;
        chk("t4_terr_hold_rvalid", m1_rvalid, 1);
        tick;
        settle;
        chk("t4_idle_m1_rvalid", m1_rvalid, 0);
        s_rvalid = 1'b0;

        // 5: m1 back-pressures with rready=0 for 3 cycles
        m1_araddr = 32'h500; m1_arvalid = 1'b1; m1_rready = 1'b0;
        settle;
        tick;
        m1_arvalid = 1'b0;
        tick;
        s_rvalid = 1'b1; s_rdata = 64'h55;
        for (int i = 0; i < 3; i++) begin
            settle;
            chk("t5_stall_rvalid",  m1_rvalid, 1);
            chk("t5_stall_rdata",   m1_rdata, 64'h55);
            chk("t5_stall_s_rready", s_rready, 0);
            tick;
        end
        m1_rready = 1'b1;
        settle;
        chk("t5_s_rready", s_rready, 1);
        tick;
        settle;
        chk("t5_done_m1_rvalid", m1_rvalid, 0);
        s_rvalid = 1'b0;

        // 6: reset during DATA, then a clean transaction
        m0_araddr = 32'h600; m0_arvalid = 1'b1; m0_rready = 1'b1;
        settle;
        tick;
        m0_arvalid = 1'b0;
        tick;
        settle;
        chk("t6_in_data_s_rready", s_rready, 1);
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        settle;
        chk("t6_rst_s_arvalid", s_arvalid, 0);
        chk("t6_rst_s_rready",  s_rready, 0);
        chk("t6_rst_m0_rvalid", m0_rvalid, 0);
        chk("t6_rst_s_araddr",  s_araddr, 0);
        m0_araddr = 32'h700; m0_arvalid = 1'b1;
        settle;
        chk("t6_m0_arready", m0_arready, 1);
        tick;
        m0_arvalid = 1'b0;
        settle;
        chk("t6_s_araddr", s_araddr, 32'h700);
        tick;
        s_rvalid = 1'b1; s_rdata = 64'h77;
        settle;
        chk("t6_m0_rvalid", m0_rvalid, 1);
        chk("t6_m0_rdata",  m0_rdata, 64'h77);
        tick;
        s_rvalid = 1'b0;
        settle;
        chk("t6_done_m0_rvalid", m0_rvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
